// File: rtl/veggie_banked_rf.sv
// veggie_banked_rf: banked vector register file, one read and one write per bank per cycle,
// with a READY/CONFLICT FSM that serialises bank conflicts. Optional macro: VEGGIE_RF_BYPASS_EN.
module veggie_banked_rf #(
    parameter int NUM_BANKS   = 4,
    parameter int NUM_VREGS   = 64,
    parameter int READ_PORTS  = 4,
    parameter int WRITE_PORTS = 4,
    parameter int VLMAX       = 32,
    parameter int ESZ         = 16,
    parameter int VIDX_W      = 8
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic [READ_PORTS-1:0]                     REN,
    input  logic [READ_PORTS-1:0][VIDX_W-1:0]         vs,
    input  logic [WRITE_PORTS-1:0]                    WEN,
    input  logic [WRITE_PORTS-1:0][VIDX_W-1:0]        vd,
    input  logic [WRITE_PORTS-1:0][VLMAX*ESZ-1:0]     vdata,
    output logic [READ_PORTS-1:0][VLMAX*ESZ-1:0]      vreg,
    output logic [READ_PORTS-1:0]                     dvalid,
    output logic                                      ready
);

    localparam int DW     = VLMAX * ESZ;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int REG_W  = $clog2(NUM_VREGS);

    typedef enum logic {
        READY,
        CONFLICT
    } state_t;

    state_t state;
    state_t next_state;

    logic [READ_PORTS-1:0]                  pend_ren;
    logic [WRITE_PORTS-1:0]                 pend_wen;
    logic [READ_PORTS-1:0][REG_W-1:0]       lat_vs;
    logic [WRITE_PORTS-1:0][REG_W-1:0]      lat_vd;
    logic [WRITE_PORTS-1:0][DW-1:0]         lat_vdata;

    logic [READ_PORTS-1:0]                  cur_ren;
    logic [WRITE_PORTS-1:0]                 cur_wen;
    logic [READ_PORTS-1:0][REG_W-1:0]       cur_rreg;
    logic [WRITE_PORTS-1:0][REG_W-1:0]      cur_wreg;
    logic [WRITE_PORTS-1:0][DW-1:0]         cur_wdata;

    logic [READ_PORTS-1:0]                  rd_grant;
    logic [WRITE_PORTS-1:0]                 wr_grant;
    logic [READ_PORTS-1:0]                  rem_ren;
    logic [WRITE_PORTS-1:0]                 rem_wen;

    logic [NUM_BANKS-1:0]                   bank_rd_act;
    logic [NUM_BANKS-1:0][REG_W-1:0]        bank_ridx;
    logic [NUM_BANKS-1:0]                   bank_wr_act;
    logic [NUM_BANKS-1:0][REG_W-1:0]        bank_widx;
    logic [NUM_BANKS-1:0][DW-1:0]           bank_wdata;
    logic [NUM_BANKS-1:0][DW-1:0]           bank_rdata;

    logic [DW-1:0] mem [NUM_VREGS];

    // Register-select bits above REG_W carry no meaning.
    logic unused_idx_bits;
    assign unused_idx_bits = ^{vs, vd};

    assign ready = (state == READY);

    // Fresh requests are only looked at in READY; CONFLICT works off the latched batch.
    always_comb begin
        cur_ren   = (state == READY) ? REN : pend_ren;
        cur_wen   = (state == READY) ? WEN : pend_wen;
        cur_wdata = (state == READY) ? vdata : lat_vdata;
        cur_rreg  = '0;
        cur_wreg  = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            cur_rreg[p] = (state == READY) ? vs[p][REG_W-1:0] : lat_vs[p];
        end
        for (int p = 0; p < WRITE_PORTS; p++) begin
            cur_wreg[p] = (state == READY) ? vd[p][REG_W-1:0] : lat_vd[p];
        end
    end

    always_comb begin
        rd_grant    = '0;
        wr_grant    = '0;
        bank_rd_act = '0;
        bank_ridx   = '0;
        bank_wr_act = '0;
        bank_widx   = '0;
        bank_wdata  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < READ_PORTS; p++) begin
                if (!bank_rd_act[b] && cur_ren[p] && (cur_rreg[p][BANK_W-1:0] == BANK_W'(b))) begin
                    bank_rd_act[b] = 1'b1;
                    bank_ridx[b]   = cur_rreg[p];
                end
            end
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (!bank_wr_act[b] && cur_wen[p] && (cur_wreg[p][BANK_W-1:0] == BANK_W'(b))) begin
                    bank_wr_act[b] = 1'b1;
                    bank_widx[b]   = cur_wreg[p];
                    bank_wdata[b]  = cur_wdata[p];
                    wr_grant[p]    = 1'b1;
                end
            end
        end
        // Every port reading the register its bank chose rides on the same access.
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_grant[p] = cur_ren[p] && bank_rd_act[cur_rreg[p][BANK_W-1:0]]
                          && (bank_ridx[cur_rreg[p][BANK_W-1:0]] == cur_rreg[p]);
        end
    end

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rdata[b] = mem[bank_ridx[b]];
`ifdef VEGGIE_RF_BYPASS_EN
            if (bank_wr_act[b] && (bank_widx[b] == bank_ridx[b])) begin
                bank_rdata[b] = bank_wdata[b];
            end
`endif
        end
    end

    always_comb begin
        rem_ren    = cur_ren & ~rd_grant;
        rem_wen    = cur_wen & ~wr_grant;
        next_state = state;
        case (state)
            READY: begin
                if ((|rem_ren) || (|rem_wen)) begin
                    next_state = CONFLICT;
                end
            end
            CONFLICT: begin
                if (!(|rem_ren) && !(|rem_wen)) begin
                    next_state = READY;
                end
            end
            default: next_state = READY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= READY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_ren  <= '0;
            pend_wen  <= '0;
            lat_vs    <= '0;
            lat_vd    <= '0;
            lat_vdata <= '0;
            dvalid    <= '0;
            vreg      <= '0;
        end else begin
            pend_ren <= rem_ren;
            pend_wen <= rem_wen;
            if (state == READY) begin
                lat_vs    <= cur_rreg;
                lat_vd    <= cur_wreg;
                lat_vdata <= vdata;
            end
            dvalid <= rd_grant;
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rd_grant[p]) begin
                    vreg[p] <= bank_rdata[cur_rreg[p][BANK_W-1:0]];
                end
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_wr_act[b]) begin
                mem[bank_widx[b]] <= bank_wdata[b];
            end
        end
    end

endmodule

// File: tb/tb_veggie_banked_rf.sv
// Directed self-checking bench for veggie_banked_rf with default parameters.
module tb_veggie_banked_rf;

    localparam int DW = 512;

    logic                 CLK;
    logic                 RST;
    logic [3:0]           REN;
    logic [3:0][7:0]      vs;
    logic [3:0]           WEN;
    logic [3:0][7:0]      vd;
    logic [3:0][DW-1:0]   vdata;
    logic [3:0][DW-1:0]   vreg;
    logic [3:0]           dvalid;
    logic                 ready;

    int testCount = 0;
    int failCount = 0;

    veggie_banked_rf dut (
        .CLK    (CLK),
        .RST    (RST),
        .REN    (REN),
        .vs     (vs),
        .WEN    (WEN),
        .vd     (vd),
        .vdata  (vdata),
        .vreg   (vreg),
        .dvalid (dvalid),
        .ready  (ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] fill(input logic [15:0] e);
        return {32{e}};
    endfunction

    // Register v holds element value v, except v0 which gets 0x00F0 so it differs from reset.
    function automatic logic [DW-1:0] pat(input int v);
        return fill((v == 0) ? 16'h00F0 : 16'(v));
    endfunction

    function automatic logic [3:0][7:0] idx4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] ren, input logic [3:0][7:0] rvs,
                                 input logic [3:0] wen, input logic [3:0][7:0] wvd,
                                 input logic [3:0][DW-1:0] wdata);
        REN   = ren;
        vs    = rvs;
        WEN   = wen;
        vd    = wvd;
        vdata = wdata;
    endtask

    task automatic idle();
        applyStimulus('0, '0, '0, '0, '0);
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [DW-1:0] expBypass;

    initial begin
        RST = 1'b1;
        idle();
        tick();
        tick();
        checkOutput("reset ready", DW'(ready), DW'(1));
        checkOutput("reset dvalid", DW'(dvalid), '0);
        checkOutput("reset vreg0", vreg[0], '0);
        RST = 1'b0;

        // Preload v0..v19, four registers per batch, one per bank.
        for (int base = 0; base <= 16; base += 4) begin
            applyStimulus(4'b0000, '0, 4'b1111, idx4(base, base + 1, base + 2, base + 3),
                          {pat(base + 3), pat(base + 2), pat(base + 1), pat(base)});
            tick();
            checkOutput($sformatf("preload ready v%0d", base), DW'(ready), DW'(1));
        end
        idle();

        // Conflict-free read of four banks.
        applyStimulus(4'b1111, idx4(0, 1, 2, 3), '0, '0, '0);
        tick();
        idle();
        checkOutput("nocf ready", DW'(ready), DW'(1));
        checkOutput("nocf dvalid", DW'(dvalid), DW'(4'b1111));
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("nocf vreg%0d", p), vreg[p], pat(p));
        end

        // All four reads hit bank 0; stale requests stay on the pins while ready is low.
        applyStimulus(4'b1111, idx4(4, 8, 12, 16), '0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) idle();
            tick();
            checkOutput($sformatf("bank0 ready c%0d", k + 1), DW'(ready), DW'((k == 3) ? 1 : 0));
            checkOutput($sformatf("bank0 dvalid c%0d", k + 1), DW'(dvalid), DW'(1 << k));
            checkOutput($sformatf("bank0 vreg%0d", k), vreg[k], pat(4 * (k + 1)));
        end
        checkOutput("bank0 vreg0 hold", vreg[0], pat(4));
        tick();
        checkOutput("bank0 no extra dvalid", DW'(dvalid), '0);

        // Same register on every port coalesces into one access.
        applyStimulus(4'b1111, idx4(5, 5, 5, 5), '0, '0, '0);
        tick();
        idle();
        checkOutput("coal ready", DW'(ready), DW'(1));
        checkOutput("coal dvalid", DW'(dvalid), DW'(4'b1111));
        for (int p = 0; p < 4; p++) begin
            checkOutput($sformatf("coal vreg%0d", p), vreg[p], pat(5));
        end

        // Two writes to v8: port 0 first, port 1 next cycle, so port 1's data wins.
        applyStimulus('0, '0, 4'b0011, idx4(8, 8, 0, 0),
                      {fill(16'h0), fill(16'h0), fill(16'hBBBB), fill(16'hAAAA)});
        tick();
        idle();
        checkOutput("ww ready c1", DW'(ready), DW'(0));
        tick();
        checkOutput("ww ready c2", DW'(ready), DW'(1));
        applyStimulus(4'b0001, idx4(8, 0, 0, 0), '0, '0, '0);
        tick();
        idle();
        checkOutput("ww dvalid", DW'(dvalid), DW'(4'b0001));
        checkOutput("ww vreg0", vreg[0], fill(16'hBBBB));

        // Same-cycle read and write of v3.
`ifdef VEGGIE_RF_BYPASS_EN
        expBypass = fill(16'h1234);
`else
        expBypass = pat(3);
`endif
        applyStimulus(4'b0001, idx4(3, 0, 0, 0), 4'b0001, idx4(3, 0, 0, 0),
                      {fill(16'h0), fill(16'h0), fill(16'h0), fill(16'h1234)});
        tick();
        idle();
        checkOutput("rw ready", DW'(ready), DW'(1));
        checkOutput("rw same-cycle vreg0", vreg[0], expBypass);
        applyStimulus(4'b0001, idx4(3, 0, 0, 0), '0, '0, '0);
        tick();
        idle();
        checkOutput("rw later vreg0", vreg[0], fill(16'h1234));

        // Reset in the middle of a conflict drain.
        applyStimulus(4'b1111, idx4(4, 8, 12, 16), '0, '0, '0);
        tick();
        idle();
        checkOutput("rstcf dvalid c1", DW'(dvalid), DW'(4'b0001));
        checkOutput("rstcf ready c1", DW'(ready), DW'(0));
        #2;
        RST = 1'b1;
        #1;
        checkOutput("rstcf async ready", DW'(ready), DW'(1));
        checkOutput("rstcf async dvalid", DW'(dvalid), '0);
        checkOutput("rstcf async vreg0", vreg[0], '0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("rstcf dvalid after c%0d", k), DW'(dvalid), '0);
            checkOutput($sformatf("rstcf ready after c%0d", k), DW'(ready), DW'(1));
        end

        // Storage survives reset.
        applyStimulus(4'b0011, idx4(5, 8, 0, 0), '0, '0, '0);
        tick();
        idle();
        checkOutput("post-rst dvalid", DW'(dvalid), DW'(4'b0011));
        checkOutput("post-rst v5", vreg[0], pat(5));
        checkOutput("post-rst v8", vreg[1], fill(16'hBBBB));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/veggie_banked_rf.md
VEGGIE_BANKED_RF -- requirements
Module: veggie_banked_rf

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, power-of-two bank count; bank = vs[$clog2(NUM_BANKS)-1:0].
REQ-002 SHALL have parameter NUM_VREGS, default 64, total vector registers, multiple of NUM_BANKS.
REQ-003 SHALL have parameter READ_PORTS, default 4, and WRITE_PORTS, default 4.
REQ-004 SHALL have parameter VLMAX, default 32, elements per register, and ESZ, default 16, bits per element.
REQ-005 SHALL have parameter VIDX_W, default 8, register-select width; upper unused bits ignored.
REQ-006 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports REN in READ_PORTS and vs in READ_PORTS x VIDX_W: read requests.
REQ-009 SHALL have ports WEN in WRITE_PORTS, vd in WRITE_PORTS x VIDX_W, vdata in WRITE_PORTS x VLMAX*ESZ: write requests.
REQ-010 SHALL have ports vreg out READ_PORTS x VLMAX*ESZ and dvalid out READ_PORTS: read data and per-port valid.
REQ-011 SHALL have port ready out 1: high = new request batch accepted this cycle (to scoreboard).

Function
REQ-012 Each bank SHALL perform at most one read and one write per cycle (1R1W).
REQ-013 Requests (REN/WEN) SHALL be sampled only when ready=1; ignored while ready=0.
REQ-014 Reads from different ports to the same vs SHALL coalesce into one bank access, all such ports granted together.
REQ-015 FSM states READY, CONFLICT; reset state READY; ready=1 iff state==READY.
REQ-016 READY: if every bank has at most one distinct read vs and at most one write, all granted this cycle; stay READY.
REQ-017 READY: otherwise grant lowest-index port(s) per bank, latch remaining read/write ports into pending masks with their vs/vd/vdata, go CONFLICT.
REQ-018 CONFLICT: each cycle grant lowest-index pending read and write per bank; clear granted bits; return to READY on the cycle after the last pending bit clears.
REQ-019 Read latency SHALL be 1 cycle: vreg[p] registered, dvalid[p] pulses high exactly one cycle after grant of port p.
REQ-020 vreg[p] SHALL hold its last value until the next grant to port p.
REQ-021 Two write ports to the same vd in one batch: lower index written first, higher index written later, so the higher index wins.
REQ-022 Same-cycle read and write of the same register without bypass SHALL return the old contents.
REQ-023 Worst-case batch SHALL drain in max(READ_PORTS, WRITE_PORTS) cycles.

Reset
REQ-024 On RST: state=READY, pending masks=0, dvalid=0, vreg=0, ready=1 asynchronously.
REQ-025 Reset mid-CONFLICT SHALL drop all pending requests with no further writes or dvalid pulses.
REQ-026 Register storage SHALL NOT be reset; contents undefined until written.

Configuration
REQ-027 Macro VEGGIE_RF_BYPASS_EN defined: a read granted in the same cycle as a write to the same register SHALL return the new vdata (lowest-index write port in that cycle).
REQ-028 VEGGIE_RF_BYPASS_EN undefined: no forwarding, REQ-022 applies; all other behaviour identical.

Verification
REQ-029 Write v1=0x0001..., v2=0x0002... (patterns); read ports 0-3 with vs=0,1,2,3 -> ready stays 1, all dvalid=1 one cycle later, correct data.
REQ-030 Read ports 0-3 with vs=4,8,12,16 (all bank 0) -> ready=0 for 3 cycles, dvalid[0..3] pulse on cycles 1,2,3,4 in order.
REQ-031 Read ports 0-3 all vs=5 -> coalesced, single grant, all dvalid high together after 1 cycle, ready never drops.
REQ-032 WEN 0,1 to vd=8 with 0xAAAA.. then 0xBBBB.. -> one conflict cycle; subsequent read of v8 returns 0xBBBB..
REQ-033 Write vd=3=0x1234.. and read vs=3 same cycle -> 0x1234.. with VEGGIE_RF_BYPASS_EN, previous value without.
REQ-034 Assert RST during CONFLICT after REQ-030 stimulus -> dvalid=0, ready=1 immediately, no further dvalid pulses.
